// File: rtl/ws2812b_pixel_tx.sv
// WS2812B serial transmitter: a one-pixel holding buffer feeds a 24-bit shifter that emits
// fixed-period bits (G, R, B, MSB first), and each frame is closed with a low latch period.
module ws2812b_pixel_tx #(
    parameter int unsigned BIT_CYCLES   = 80,
    parameter int unsigned T0H_CYCLES   = 26,
    parameter int unsigned T1H_CYCLES   = 51,
    parameter int unsigned LATCH_CYCLES = 3840
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [23:0] pix_grb,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic        dout,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int unsigned CNT_MAX = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] T0H_LAST   = CW'(T0H_CYCLES - 1);
    localparam logic [CW-1:0] T1H_LAST   = CW'(T1H_CYCLES - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
          LATCH_CYCLES > 0)) begin : g_param_check
        $error("ws2812b_pixel_tx: require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [23:0]   shift_q, shift_d;
    logic          cur_last_q, cur_last_d;
    logic [23:0]   buf_data_q, buf_data_d;
    logic          buf_last_q, buf_last_d;
    logic          buf_full_q, buf_full_d;
    logic          dout_q, dout_d;
    logic          frame_done_q, frame_done_d;
    logic          underrun_q, underrun_d;
    logic          load;
    logic          accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            cur_last_q   <= 1'b0;
            buf_data_q   <= '0;
            buf_last_q   <= 1'b0;
            buf_full_q   <= 1'b0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            cur_last_q   <= cur_last_d;
            buf_data_q   <= buf_data_d;
            buf_last_q   <= buf_last_d;
            buf_full_q   <= buf_full_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        cur_last_d   = cur_last_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        load         = 1'b0;

        // The counter runs across the whole bit; HIGH->LOW happens mid-count.
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (buf_full_q) begin
                    load    = 1'b1;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == (shift_q[23] ? T1H_LAST : T0H_LAST)) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q != 5'd23) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q + 5'd1;
                        state_d   = StHigh;
                    end else if (buf_full_q && !cur_last_q) begin
                        load    = 1'b1;
                        state_d = StHigh;
                    end else begin
                        bit_idx_d  = '0;
                        state_d    = StLatch;
                        underrun_d = !cur_last_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d        = '0;
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            shift_d    = buf_data_q;
            cur_last_d = buf_last_q;
            bit_idx_d  = '0;
        end

        dout_d = (state_d == StHigh);
    end

    assign accept = pix_valid && !buf_full_q;

    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        buf_full_d = (buf_full_q && !load) || accept;
        if (accept) begin
            buf_data_d = pix_grb;
            buf_last_d = pix_last;
        end
    end

    assign pix_ready  = !buf_full_q;
    assign busy       = (state_q != StIdle) || buf_full_q;
    assign dout       = dout_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule
